// File: rtl/led_arbiter_pkg.sv
// Shared definitions for the LED arbiter.
//   state_t        : FSM state encoding (IDLE / ACTIVE / LINGER)
//   LED_OFF        : active-low RGB drive with every LED dark
//   COLOR_*_BIT    : bit positions of R, B and G inside a 3-bit color field
//   lowest_set()   : isolates the lowest set bit (highest-priority request)
//   color_to_led() : maps an active-high color to the active-low LED drive
package led_arbiter_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LINGER = 2'd2
  } state_t;

  localparam logic [2:0] LED_OFF = 3'b111;

  localparam int COLOR_R_BIT = 0;
  localparam int COLOR_B_BIT = 1;
  localparam int COLOR_G_BIT = 2;

  // Two's-complement trick: v & -v keeps only the lowest set bit.
  function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    return v & (~v + NUM_REQ'(1));
  endfunction

  function automatic logic [2:0] color_to_led(input logic [2:0] c);
    logic [2:0] l;
    l              = LED_OFF;
    l[COLOR_R_BIT] = ~c[COLOR_R_BIT];
    l[COLOR_B_BIT] = ~c[COLOR_B_BIT];
    l[COLOR_G_BIT] = ~c[COLOR_G_BIT];
    return l;
  endfunction

endpackage

// File: rtl/led_arbiter_tick_gen.sv
// Free-running timing prescaler.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high for one cycle every TICK_CYCLES cycles (while the counter
//           sits at its terminal value, so it is sampled on the wrap edge)
module tick_gen #(
  parameter int TICK_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int              CNT_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/led_arbiter.sv
// Three-requester RGB LED arbiter with minimum display time and blinking.
//   sys_clk   : single clock
//   sys_rst_n : asynchronous active-low reset
//   req       : level requests, index 0 highest priority
//   req_color : color of requester i in [3i+2:3i] (bit0 R, bit1 B, bit2 G)
//   req_blink : blink enable of requester i
//   gnt       : registered one-hot grant, or zero
//   led       : registered active-low RGB drive
//   busy      : registered, high whenever the FSM is not IDLE
module led_arbiter
  import led_arbiter_pkg::*;
#(
  parameter int TICK_CYCLES = 270000,
  parameter int MIN_HOLD    = 50,
  parameter int BLINK_TICKS = 25
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] req,
  input  logic [8:0] req_color,
  input  logic [2:0] req_blink,
  output logic [2:0] gnt,
  output logic [2:0] led,
  output logic       busy
);

  localparam logic [7:0] HOLD_LOAD  = 8'(MIN_HOLD);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);

  logic tick;

  state_t     state_q,     state_d;
  logic [2:0] gnt_q,       gnt_d;
  logic [2:0] color_q,     color_d;
  logic       blink_q,     blink_d;
  logic [7:0] hold_q,      hold_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       phase_q,     phase_d;
  logic [2:0] led_q,       led_d;
  logic       busy_q,      busy_d;
  logic       arm_q,       arm_d;

  logic       grant_evt;
  logic       any_req;
  logic       granted_live;
  logic       higher_req;
  logic [2:0] new_gnt;
  logic [2:0] new_color;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .tick (tick)
  );

  assign any_req      = |req;
  assign granted_live = |(req & gnt_q);
  // gnt_q - 1 turns a one-hot grant into a mask of all higher-priority slots.
  assign higher_req   = |(req & (gnt_q - 3'd1));
  assign new_gnt      = lowest_set(req);

  always_comb begin
    new_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (new_gnt[i]) begin
        new_color = req_color[3*i +: 3];
      end
    end
  end

  // arm_q blocks grants on the first edge after reset release.
  assign arm_d = 1'b1;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      color_q     <= '0;
      blink_q     <= 1'b0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= LED_OFF;
      busy_q      <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      color_q     <= color_d;
      blink_q     <= blink_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      arm_q       <= arm_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    grant_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_q && any_req) begin
          state_d   = ST_ACTIVE;
          grant_evt = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if ((hold_q == 8'd0) && (higher_req || !granted_live)) begin
          if (any_req) begin
            grant_evt = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!granted_live) begin
          // Hold time not yet served: keep showing the pattern without a grant.
          state_d = ST_LINGER;
        end
      end
      ST_LINGER: begin
        if (hold_q == 8'd0) begin
          if (any_req) begin
            state_d   = ST_ACTIVE;
            grant_evt = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath logic; a grant load wins over a coincident tick.
  always_comb begin
    gnt_d       = gnt_q;
    color_d     = color_q;
    blink_d     = blink_q;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (grant_evt) begin
      gnt_d       = new_gnt;
      color_d     = new_color;
      blink_d     = |(req_blink & new_gnt);
      hold_d      = HOLD_LOAD;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (state_d == ST_IDLE) begin
      gnt_d       = '0;
      color_d     = '0;
      blink_d     = 1'b0;
      hold_d      = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else begin
      if (state_d == ST_LINGER) begin
        gnt_d = '0;
      end
      if (tick) begin
        if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end
        if (blink_q) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end
      end
    end

    if (state_d == ST_IDLE) begin
      led_d = LED_OFF;
    end else if (phase_d || !blink_d) begin
      led_d = color_to_led(color_d);
    end else begin
      led_d = LED_OFF;
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign gnt  = gnt_q;
  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with TICK_CYCLES=4, MIN_HOLD=2, BLINK_TICKS=1.
// Ticks are sampled on every 4th edge after reset release (E4, E8, ...).
module tb_led_arbiter;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] req       = 3'b000;
  logic [8:0] req_color = 9'b0;
  logic [2:0] req_blink = 3'b000;
  logic [2:0] gnt;
  logic [2:0] led;
  logic       busy;

  typedef struct {
    string      tag;
    logic [2:0] gnt;
    logic [2:0] led;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  led_arbiter #(
    .TICK_CYCLES(4),
    .MIN_HOLD   (2),
    .BLINK_TICKS(1)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (req),
    .req_color(req_color),
    .req_blink(req_blink),
    .gnt      (gnt),
    .led      (led),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic push_exp(input string tag, input logic [2:0] g, input logic [2:0] l, input logic b);
    exp_t e;
    e.tag  = tag;
    e.gnt  = g;
    e.led  = l;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    n_cmp++;
    assert ({gnt, led, busy} === {e.gnt, e.led, e.busy}) else begin
      n_bad++;
      $error("FAIL %s: observed gnt=%b led=%b busy=%b, expected gnt=%b led=%b busy=%b",
             e.tag, gnt, led, busy, e.gnt, e.led, e.busy);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_edge(input string tag, input logic [2:0] g, input logic [2:0] l, input logic b);
    push_exp(tag, g, l, b);
    step();
    pop_check();
  endtask

  task automatic check_now(input string tag, input logic [2:0] g, input logic [2:0] l, input logic b);
    push_exp(tag, g, l, b);
    pop_check();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish by 50000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single request from req2, red, no blink; held before reset release.
    req       = 3'b100;
    req_color = 9'b001_000_000;
    step();
    step();
    check_now("reset_state", 3'b000, 3'b111, 1'b0);
    sys_rst_n = 1'b1;
    expect_edge("first_edge_no_grant", 3'b000, 3'b111, 1'b0);   // E1
    expect_edge("single_grant_req2",   3'b100, 3'b110, 1'b1);   // E2
    req = 3'b000;
    expect_edge("single_drop_linger",  3'b000, 3'b110, 1'b1);   // E3
    repeat (5) expect_edge("single_linger_hold", 3'b000, 3'b110, 1'b1); // E4..E8
    expect_edge("single_idle",         3'b000, 3'b111, 1'b0);   // E9

    // No preemption: req0 (blue) arrives while req2 is held.
    req = 3'b100;
    expect_edge("np_grant_req2",       3'b100, 3'b110, 1'b1);   // E10
    req            = 3'b101;
    req_color[2:0] = 3'b010;
    repeat (6) expect_edge("np_no_preempt", 3'b100, 3'b110, 1'b1); // E11..E16
    expect_edge("np_regrant_req0",     3'b001, 3'b101, 1'b1);   // E17
    req = 3'b000;
    expect_edge("np_drop_linger",      3'b000, 3'b101, 1'b1);   // E18
    repeat (6) expect_edge("np_linger", 3'b000, 3'b101, 1'b1);  // E19..E24
    expect_edge("np_idle",             3'b000, 3'b111, 1'b0);   // E25

    // Simultaneous requests: req0 wins and keeps the grant.
    req_color = 9'b001_100_010;
    req       = 3'b111;
    repeat (10) expect_edge("sim_req0_only", 3'b001, 3'b101, 1'b1); // E26..E35
    req = 3'b110;
    // E36 is also a tick edge: the fresh hold load must win over the decrement.
    expect_edge("sim_regrant_req1",    3'b010, 3'b011, 1'b1);   // E36
    req = 3'b000;
    expect_edge("sim_drop_linger",     3'b000, 3'b011, 1'b1);   // E37
    repeat (7) expect_edge("tick_vs_load_hold", 3'b000, 3'b011, 1'b1); // E38..E44
    expect_edge("sim_idle",            3'b000, 3'b111, 1'b0);   // E45

    // Blink on req1 (green), phase toggles on each tick; color change ignored.
    req_blink = 3'b010;
    req       = 3'b010;
    expect_edge("blink_grant_on",      3'b010, 3'b011, 1'b1);   // E46
    expect_edge("blink_on",            3'b010, 3'b011, 1'b1);   // E47
    req_color[5:3] = 3'b001;
    repeat (4) expect_edge("blink_off",           3'b010, 3'b111, 1'b1); // E48..E51
    repeat (4) expect_edge("blink_on_color_held", 3'b010, 3'b011, 1'b1); // E52..E55
    repeat (4) expect_edge("blink_off_again",     3'b010, 3'b111, 1'b1); // E56..E59
    req = 3'b000;
    expect_edge("blink_release_idle",  3'b000, 3'b111, 1'b0);   // E60
    req = 3'b010;
    expect_edge("regrant_new_color",   3'b010, 3'b110, 1'b1);   // E61
    req = 3'b000;
    expect_edge("enter_linger",        3'b000, 3'b110, 1'b1);   // E62

    // Asynchronous reset between edges while lingering.
    #3;
    sys_rst_n = 1'b0;
    #1;
    check_now("async_reset_mid_linger", 3'b000, 3'b111, 1'b0);
    req = 3'b001;
    #2;
    sys_rst_n = 1'b1;
    expect_edge("post_reset_no_grant", 3'b000, 3'b111, 1'b0);   // E1
    expect_edge("post_reset_grant",    3'b001, 3'b101, 1'b1);   // E2

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 270000, meaning sys_clk cycles per timing tick (10 ms at 27 MHz).
REQ-002 SHALL have parameter MIN_HOLD, default 50, meaning the minimum number of ticks a grant is displayed before it may change (range 1..255).
REQ-003 SHALL have parameter BLINK_TICKS, default 25, meaning the number of ticks per blink half-period (range 1..255).
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, 3 bits: level requests; index 0 has the highest priority.
REQ-007 SHALL have port req_color, input, 9 bits: color for requester i in bits [3i+2:3i], active-high, with bit0=R, bit1=B, bit2=G.
REQ-008 SHALL have port req_blink, input, 3 bits: blink enable for requester i.
REQ-009 SHALL have port gnt, output, 3 bits: one-hot grant, or all zeros.
REQ-010 SHALL have port led, output reg, 3 bits: active-low RGB drive (3'b110 R, 3'b101 B, 3'b011 G, 3'b111 off).
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 Tick prescaler SHALL count 0..TICK_CYCLES-1, wrap, and emit a 1-cycle tick at the wrap; it SHALL free-run and is never restarted by a grant.
REQ-013 FSM states SHALL be IDLE, ACTIVE and LINGER; all outputs SHALL be registered and change on the edge that samples the condition.
REQ-014 IDLE: gnt=0 and led=3'b111; any req bit set SHALL cause entry to ACTIVE on the next edge.
REQ-015 A grant event SHALL:
- set gnt to the lowest asserted req index;
- latch that requester's color and blink bits;
- load hold_cnt=MIN_HOLD;
- clear blink_cnt and set blink phase to on.
REQ-016 led SHALL equal ~latched_color when phase is on or latched blink=0, and 3'b111 otherwise; color input changes during a grant SHALL NOT affect led.
REQ-017 hold_cnt SHALL decrement on each tick while nonzero and saturate at 0.
REQ-018 With latched blink=1, blink_cnt SHALL advance on each tick; phase SHALL toggle and blink_cnt clear when blink_cnt reaches BLINK_TICKS-1.
REQ-019 ACTIVE, granted req drops with hold_cnt>0: the FSM SHALL go to LINGER with gnt=0 and led continuing the latched pattern.
REQ-020 ACTIVE, hold_cnt=0 and (a higher-priority req is asserted or the granted req has dropped): the arbiter SHALL re-grant if any req is asserted, otherwise go to IDLE.
REQ-021 ACTIVE, hold_cnt>0: a higher-priority req SHALL NOT preempt the current grant.
REQ-022 LINGER, hold_cnt reaches 0: the arbiter SHALL re-grant if any req is asserted, otherwise go to IDLE.
REQ-023 LINGER, a req appears before hold expiry: it SHALL be ignored until hold_cnt=0.
REQ-024 Tick coinciding with a transition: the grant event load of REQ-015 SHALL take priority over the decrement.
REQ-025 The same requester re-requesting after release SHALL be treated as a new grant event.

Reset
REQ-026 sys_rst_n low SHALL asynchronously force IDLE, gnt=0, led=3'b111, busy=0, and clear all counters, latches and phase, including mid-grant or mid-LINGER.
REQ-027 The first grant after reset release SHALL occur no earlier than the second rising edge of sys_clk.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the LED_OFF=3'b111 constant and the color bit indices.
REQ-029 The tick prescaler SHALL be a sub-module named tick_gen, parameterized by TICK_CYCLES, with a 1-bit tick output.

Verification (TICK_CYCLES=4, MIN_HOLD=2, BLINK_TICKS=1)
REQ-030 Bench SHALL cover single request: req=3'b100 with color 3'b001, no blink -> gnt=3'b100, led=3'b110 one cycle later; req dropped -> LINGER until 2 ticks elapse -> IDLE with led=3'b111.
REQ-031 Bench SHALL cover no preemption: req2 granted, req0 asserted at the next cycle -> gnt stays 3'b100 until hold_cnt=0, then gnt=3'b001 with led=~req0 color.
REQ-032 Bench SHALL cover simultaneous requests: req=3'b111 from IDLE -> gnt=3'b001, and req1/req2 are never granted while req0 stays high.
REQ-033 Bench SHALL cover blink: req1 with blink=1 and color 3'b100 -> led alternates 3'b011/3'b111 every 4 cycles, starting on.
REQ-034 Bench SHALL cover reset mid-LINGER: sys_rst_n pulsed low between clock edges -> led=3'b111, gnt=0 and busy=0 immediately, before the next edge.
REQ-035 Bench SHALL cover color change during grant: req_color changed while granted -> led unchanged until the next grant event.
